// File: rtl/gpioemu_result_fifo.sv
// rtl/gpioemu_result_fifo.sv - result capture FIFO behind the emulator slave bus
// Entries are {ok, popcount, W}; software drains via STATUS / DATA_W / DATA_L (pop) / CTRL.
module gpioemu_result_fifo #(
  parameter int          DEPTH  = 8,
  parameter int          THRESH = 1,
  parameter logic [15:0] BASE   = 16'h03B0
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       res_valid,
  input  logic [31:0]                res_w,
  input  logic [5:0]                 res_l,
  input  logic                       res_ok,
  input  logic [15:0]                saddress,
  input  logic                       srd,
  input  logic                       swr,
  input  logic [31:0]                sdata_in,
  output logic [31:0]                sdata_out,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       fifo_irq
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 39;

  localparam logic [15:0]   A_STATUS = BASE;
  localparam logic [15:0]   A_DATA_W = BASE + 16'd8;
  localparam logic [15:0]   A_DATA_L = BASE + 16'd16;
  localparam logic [15:0]   A_CTRL   = BASE + 16'd24;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_sticky_q, drop_sticky_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic [31:0]   sdata_q, sdata_d;
  logic          srd_prev_q, swr_prev_q;

  logic [EW-1:0] mem [DEPTH];

  logic          rd_ev, wr_ev;
  logic          sel_status, sel_w, sel_l, sel_ctrl;
  logic          empty, full;
  logic [EW-1:0] head;
  logic [EW-1:0] entry;
  logic          pop_en, push_en, drop, flush, clr;
  logic [31:0]   status_word;
  logic          unused_sdata;

  assign unused_sdata = &{1'b0, sdata_in[31:2]};

  // Edge-detect the level strobes so a long srd/swr acts exactly once.
  assign rd_ev = srd & ~srd_prev_q;
  assign wr_ev = swr & ~swr_prev_q;

  assign sel_status = (saddress == A_STATUS);
  assign sel_w      = (saddress == A_DATA_W);
  assign sel_l      = (saddress == A_DATA_L);
  assign sel_ctrl   = (saddress == A_CTRL);

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign head  = mem[rd_ptr_q];
  assign entry = {res_ok, res_l, res_w};

  assign flush   = wr_ev & sel_ctrl & sdata_in[0];
  assign clr     = wr_ev & sel_ctrl & sdata_in[1];
  assign pop_en  = rd_ev & sel_l & ~empty & ~flush;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_en = res_valid & (~full | pop_en) & ~flush;
  assign drop    = res_valid & full & ~pop_en & ~flush;

  assign status_word = {8'h00, drop_count_q, 5'h00, drop_sticky_q, full, empty, 8'(count_q)};

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    drop_sticky_d = drop_sticky_q;
    drop_count_d  = drop_count_q;
    sdata_d       = sdata_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (clr) begin
      drop_sticky_d = 1'b0;
      drop_count_d  = 8'h00;
    end else if (drop) begin
      drop_sticky_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end

    if (rd_ev) begin
      if (sel_status)
        sdata_d = status_word;
      else if (sel_w && !empty)
        sdata_d = head[31:0];
      else if (sel_l && !empty)
        sdata_d = {24'h0, head[38], 1'b0, head[37:32]};
      else
        sdata_d = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drop_sticky_q <= 1'b0;
      drop_count_q  <= 8'h00;
      sdata_q       <= 32'h0;
      srd_prev_q    <= 1'b0;
      swr_prev_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drop_sticky_q <= drop_sticky_d;
      drop_count_q  <= drop_count_d;
      sdata_q       <= sdata_d;
      srd_prev_q    <= srd;
      swr_prev_q    <= swr;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= entry;
  end

  assign sdata_out  = sdata_q;
  assign fifo_count = count_q;
  assign fifo_irq   = (count_q >= THRESH_C) | drop_sticky_q;

endmodule

// File: doc/gpioemu_result_fifo.md
Name: gpioemu_result_fifo

Overview:
Downstream stage of the emulated multiplier/popcount core. Captures each completed result (32-bit product W, popcount L, range-valid flag) on a one-cycle completion pulse into a small FIFO. Software drains it over the same slave bus (saddress/srd/swr) used by the core. Raises an interrupt-style level when data is pending beyond a threshold or results were lost.

Parameters:
DEPTH, 8, number of result entries (power of two, 2..64)
THRESH, 1, fifo_irq asserts when occupancy >= THRESH
BASE, 16'h03B0, base of the 4-register window (STATUS=BASE, DATA_W=BASE+8, DATA_L=BASE+16, CTRL=BASE+24)

Ports:
clk  in  1  system clock, all state on rising edge
n_reset  in  1  asynchronous active-low reset
res_valid  in  1  one-cycle pulse: result fields valid this cycle
res_w  in  32  product low word W
res_l  in  6  popcount of W (0..32)
res_ok  in  1  1 = product fitted in 32 bits
saddress  in  16  slave address
srd  in  1  read strobe, synchronous to clk, level, may span many cycles
swr  in  1  write strobe, same rules as srd
sdata_in  in  32  write data
sdata_out  out  32  registered read data
fifo_count  out  clog2(DEPTH+1)  current occupancy
fifo_irq  out  1  (count >= THRESH) OR drop_sticky

Behaviour:
- Reset (n_reset low, async): wr_ptr, rd_ptr, count, drop_sticky, drop_count, sdata_out all 0; fifo_irq 0; storage contents don't-care. Reset mid-access aborts it; no partial pop.
- Strobe detection: srd_d/swr_d registered copies; read event = srd & ~srd_d, write event = swr & ~swr_d. Exactly one action per strobe regardless of length. Addresses outside the window: reads return 0, writes ignored.
- Entry format: {res_ok, res_l[5:0], res_w[31:0]} (39 bits).
- Push: on clk edge with res_valid=1 and count<DEPTH (or a same-edge pop frees space): store at wr_ptr, wr_ptr+1 mod DEPTH.
- Full push: res_valid with count==DEPTH and no same-edge pop -> entry dropped, drop_sticky<=1, drop_count+1 saturating at 255.
- Read STATUS: sdata_out <= {8'h0, drop_count[7:0], 5'h0, drop_sticky, full, empty, count zero-extended to 8 bits}. No side effects.
- Read DATA_W: sdata_out <= head W (0 if empty). No pop.
- Read DATA_L: sdata_out <= {24'h0, res_ok, 1'b0, res_l} of head, then pop (rd_ptr+1, count-1). Empty: sdata_out <= 0, no pop, no error.
- Write CTRL: bit0=1 flush (pointers, count to 0); bit1=1 clear drop_sticky and drop_count. Other bits ignored.
- Simultaneous push+pop, non-empty: both take effect, count unchanged. Push+pop when full: both succeed, no drop. Push+pop-attempt when empty: push only, read returns 0.
- Flush same edge as push: flush wins, pushed result discarded, not counted as drop.
- sdata_out held until next read event in window; out-of-window reads load 0.
- Latency: result pushed on edge N visible in STATUS/DATA_W from read event on edge N+1. fifo_count and fifo_irq registered/derived from registers, update the edge after the event.
- Pointers wrap mod DEPTH; count never exceeds DEPTH nor underflows.

Test Plan:
- Reset then read STATUS -> sdata_out=32'h0000_0100 (empty=1, count 0); fifo_irq=0.
- Push W=32'h0000_0006, L=2, ok=1 -> fifo_count=1, fifo_irq=1; read DATA_W -> 32'h0000_0006; read DATA_L -> 32'h0000_0082; STATUS back to 32'h0000_0100.
- Push 10 results (W=1..10) with no reads -> count=8, STATUS=32'h0002_0608 (drop_count 2, sticky, full); drain -> W values 1..8 in order, 9th DATA_L read returns 0.
- Full FIFO, res_valid and DATA_L read event on same edge -> no drop, count stays 8; drained order still FIFO with new entry last.
- Hold srd high 20 cycles on DATA_L with 3 entries -> exactly one pop, count=2.
- Write CTRL=3 same edge as res_valid -> count=0, drop_count=0, drop_sticky=0, fifo_irq=0; assert n_reset low mid-srd -> all outputs 0 immediately.
